conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter SIZE, default 32, output word width in bits; legal values 16 or 32.
REQ-002 Parameter COM, default 8'hBC, alignment symbol that opens a frame.
REQ-003 Parameter GAP_MAX, default 3, maximum consecutive idle cycles tolerated inside a word.
REQ-004 PCLK  in  1  sole clock, rising-edge active.
REQ-005 RESET  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 VALID_IN  in  1  DATA_IN carries a byte this cycle.
REQ-007 DATA_IN  in  8  input byte.
REQ-008 MODE  in  1  0 = 4 bytes/word, 1 = 2 bytes/word; forced to 1 when SIZE=16.
REQ-009 DATA_OUT  out  SIZE  assembled word.
REQ-010 VALID_OUT  out  1  one-cycle strobe, DATA_OUT complete.
REQ-011 ALIGNED  out  1  high while FSM is in ASSEMBLE.
REQ-012 ERR_FRAME  out  1  one-cycle strobe on discarded partial word.
REQ-013 WORD_CNT  out  16  words delivered (see Configuration).

Function
REQ-014 FSM states: IDLE, SEARCH, ASSEMBLE; all outputs registered.
REQ-015 IDLE -> SEARCH on the first cycle with VALID_IN=1; that byte is also evaluated as a SEARCH byte.
REQ-016 SEARCH: bytes other than COM are dropped; VALID_IN=1 with DATA_IN==COM -> ASSEMBLE, byte counter=0, MODE latched into internal N (4 or 2).
REQ-017 MODE is sampled only on the SEARCH->ASSEMBLE transition and on COM realign; changes during ASSEMBLE are ignored.
REQ-018 ASSEMBLE: each non-COM byte with VALID_IN=1 is written to bits [8*cnt+7:8*cnt] of the shadow word; cnt increments.
REQ-019 When the byte at cnt=N-1 is sampled, DATA_OUT loads the full word on that same edge, VALID_OUT=1 for exactly one cycle, cnt wraps to 0; zero-bubble back-to-back words are supported.
REQ-020 N=2: DATA_OUT[SIZE-1:16] = 0.
REQ-021 DATA_OUT holds its last value between strobes.
REQ-022 COM in ASSEMBLE with cnt=0: consumed as realign, no strobe, MODE re-latched.
REQ-023 COM in ASSEMBLE with cnt!=0: partial word discarded, ERR_FRAME pulses 1 cycle, cnt=0, remain ASSEMBLE, MODE re-latched.
REQ-024 Idle counter counts consecutive VALID_IN=0 cycles in ASSEMBLE with cnt!=0; reaching GAP_MAX+1 -> partial discarded, ERR_FRAME pulse, state SEARCH, cnt=0.
REQ-025 Idle cycles with cnt=0 do not count and never cause an error.
REQ-026 VALID_IN=0 ignores DATA_IN in every state.

Reset
REQ-027 RESET=0 asynchronously forces: state IDLE, cnt=0, idle counter=0, DATA_OUT=0, VALID_OUT=0, ALIGNED=0, ERR_FRAME=0, WORD_CNT=0.
REQ-028 Reset asserted mid-word discards the partial word with no ERR_FRAME; after release, a fresh COM is required.

Configuration
REQ-029 Macro CONV_CTRL_WORD_CNT_EN defined: WORD_CNT increments on every VALID_OUT, saturating at 16'hFFFF.
REQ-030 Macro undefined: no counter logic; WORD_CNT tied to 0; all other behaviour identical.

Verification
REQ-031 SIZE=32, MODE=0, bytes BC,01,02,03,04 consecutive -> DATA_OUT=32'h04030201, VALID_OUT high one cycle at the edge sampling 04.
REQ-032 MODE=1, bytes BC,11,22,33,44 -> DATA_OUT=32'h00002211 then 32'h00004433 on consecutive-pair strobes; no bubble.
REQ-033 MODE=0, bytes BC,01,02,BC,0A,0B,0C,0D -> ERR_FRAME pulse at the second BC; next strobe DATA_OUT=32'h0D0C0B0A.
REQ-034 GAP_MAX=3, BC,01,02, then 4 idle cycles, then 05,06,07,08 -> ERR_FRAME pulse, ALIGNED=0, no VALID_OUT until a new BC.
REQ-035 RESET low after BC,01,02 -> all outputs 0 immediately (async); after release, bytes 03,04,05,06 produce no strobe.
REQ-036 With CONV_CTRL_WORD_CNT_EN, 3 complete words -> WORD_CNT=3; without the macro -> WORD_CNT=0.

Source files
------------

// File: rtl/conv_ctrl.sv
// Byte-to-word converter: aligns on COM, assembles 2- or 4-byte little-endian words.
// Optional WORD_CNT counter is built when CONV_CTRL_WORD_CNT_EN is defined.
module conv_ctrl #(
  parameter int unsigned SIZE    = 32,
  parameter logic [7:0]  COM     = 8'hBC,
  parameter int unsigned GAP_MAX = 3
) (
  input  logic            PCLK,
  input  logic            RESET,
  input  logic            VALID_IN,
  input  logic [7:0]      DATA_IN,
  input  logic            MODE,
  output logic [SIZE-1:0] DATA_OUT,
  output logic            VALID_OUT,
  output logic            ALIGNED,
  output logic            ERR_FRAME,
  output logic [15:0]     WORD_CNT
);

  typedef enum logic [1:0] {IDLE, SEARCH, ASSEMBLE} state_t;

  localparam logic [7:0] GAP_LIM = 8'(GAP_MAX);

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic [7:0]      idle_q;
  logic            n2_q;
  logic [23:0]     shadow_q;
  logic [SIZE-1:0] data_q;
  logic            valid_q;
  logic            aligned_q;
  logic            err_q;

  logic        mode_n2;
  logic        is_com;
  logic        last_byte;
  logic        word_done;
  logic [31:0] word_full;

  assign mode_n2   = (SIZE == 16) ? 1'b1 : MODE;
  assign is_com    = VALID_IN && (DATA_IN == COM);
  assign last_byte = (cnt_q == (n2_q ? 2'd1 : 2'd3));
  assign word_done = (state_q == ASSEMBLE) && VALID_IN && !is_com && last_byte;

  // The final byte bypasses the shadow so the word is presented on the edge that samples it.
  always_comb begin
    word_full = '0;
    if (n2_q) word_full = {16'h0000, DATA_IN, shadow_q[7:0]};
    else      word_full = {DATA_IN, shadow_q};
  end

  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idle_q    <= '0;
      n2_q      <= 1'b0;
      shadow_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE, SEARCH: begin
          if (is_com) begin
            state_q   <= ASSEMBLE;
            aligned_q <= 1'b1;
            cnt_q     <= '0;
            idle_q    <= '0;
            n2_q      <= mode_n2;
          end else if (VALID_IN) begin
            state_q <= SEARCH;
          end
        end
        ASSEMBLE: begin
          if (is_com) begin
            err_q  <= (cnt_q != 2'd0);
            cnt_q  <= '0;
            idle_q <= '0;
            n2_q   <= mode_n2;
          end else if (VALID_IN) begin
            idle_q <= '0;
            if (last_byte) begin
              data_q  <= word_full[SIZE-1:0];
              valid_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              case (cnt_q)
                2'd0:    shadow_q[7:0]   <= DATA_IN;
                2'd1:    shadow_q[15:8]  <= DATA_IN;
                default: shadow_q[23:16] <= DATA_IN;
              endcase
              cnt_q <= cnt_q + 2'd1;
            end
          end else if (cnt_q != 2'd0) begin
            if (idle_q == GAP_LIM) begin
              err_q     <= 1'b1;
              state_q   <= SEARCH;
              aligned_q <= 1'b0;
              cnt_q     <= '0;
              idle_q    <= '0;
            end else begin
              idle_q <= idle_q + 8'd1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          aligned_q <= 1'b0;
        end
      endcase
    end
  end

  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign ALIGNED   = aligned_q;
  assign ERR_FRAME = err_q;

`ifdef CONV_CTRL_WORD_CNT_EN
  logic [15:0] wcnt_q;

  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      wcnt_q <= '0;
    end else if (word_done && (wcnt_q != 16'hFFFF)) begin
      wcnt_q <= wcnt_q + 16'd1;
    end
  end

  assign WORD_CNT = wcnt_q;
`else
  logic unused_word_done;
  assign unused_word_done = word_done;
  assign WORD_CNT = '0;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed self-checking bench for conv_ctrl (SIZE=32, COM=BC, GAP_MAX=3).
module tb_conv_ctrl;

  logic        PCLK = 1'b0;
  logic        RESET = 1'b0;
  logic        VALID_IN = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        MODE = 1'b0;
  logic [31:0] DATA_OUT;
  logic        VALID_OUT;
  logic        ALIGNED;
  logic        ERR_FRAME;
  logic [15:0] WORD_CNT;

  int checks = 0;
  int errors = 0;

`ifdef CONV_CTRL_WORD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  conv_ctrl #(.SIZE(32), .COM(8'hBC), .GAP_MAX(3)) dut (
    .PCLK(PCLK), .RESET(RESET), .VALID_IN(VALID_IN), .DATA_IN(DATA_IN), .MODE(MODE),
    .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .ALIGNED(ALIGNED),
    .ERR_FRAME(ERR_FRAME), .WORD_CNT(WORD_CNT)
  );

  always #5 PCLK = ~PCLK;

  // Drive one cycle; on return the outputs reflect the edge that sampled it.
  task automatic drive(input logic v, input logic [7:0] d);
    VALID_IN = v;
    DATA_IN  = d;
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset;
    RESET    = 1'b0;
    VALID_IN = 1'b0;
    @(posedge PCLK);
    #1;
    RESET = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge PCLK);
    #1;
    checks++; if (DATA_OUT !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp %h", DATA_OUT, 32'h0); end
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", VALID_OUT); end
    checks++; if (ALIGNED !== 1'b0) begin errors++; $display("FAIL rst_aligned: got %b exp 0", ALIGNED); end
    checks++; if (ERR_FRAME !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", ERR_FRAME); end
    checks++; if (WORD_CNT !== 16'h0) begin errors++; $display("FAIL rst_wcnt: got %h exp 0", WORD_CNT); end
    RESET = 1'b1;
  endtask

  task automatic test_mode0;
    logic [7:0] seq  [5] = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
    logic       vexp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    MODE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i]);
      checks++; if (VALID_OUT !== vexp[i]) begin errors++; $display("FAIL m0_valid[%0d]: got %b exp %b", i, VALID_OUT, vexp[i]); end
      checks++; if (ALIGNED !== 1'b1) begin errors++; $display("FAIL m0_aligned[%0d]: got %b exp 1", i, ALIGNED); end
    end
    checks++; if (DATA_OUT !== 32'h04030201) begin errors++; $display("FAIL m0_data: got %h exp 04030201", DATA_OUT); end
    drive(1'b0, 8'h55);
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL m0_strobe_len: got %b exp 0", VALID_OUT); end
    checks++; if (DATA_OUT !== 32'h04030201) begin errors++; $display("FAIL m0_hold: got %h exp 04030201", DATA_OUT); end
    checks++; if (WORD_CNT !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL m0_wcnt: got %0d exp %0d", WORD_CNT, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  seq1 [5] = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'h44};
    logic        v1   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] d1   [5] = '{32'h0, 32'h0, 32'h00002211, 32'h0, 32'h00004433};
    logic [7:0]  seq0 [9] = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic        v0   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] d0   [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h04030201, 32'h0, 32'h0, 32'h0, 32'h08070605};
    do_reset();
    MODE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq1[i]);
      checks++; if (VALID_OUT !== v1[i]) begin errors++; $display("FAIL b2b_m1_valid[%0d]: got %b exp %b", i, VALID_OUT, v1[i]); end
      if (v1[i]) begin
        checks++; if (DATA_OUT !== d1[i]) begin errors++; $display("FAIL b2b_m1_data[%0d]: got %h exp %h", i, DATA_OUT, d1[i]); end
      end
    end
    do_reset();
    MODE = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, seq0[i]);
      checks++; if (VALID_OUT !== v0[i]) begin errors++; $display("FAIL b2b_m0_valid[%0d]: got %b exp %b", i, VALID_OUT, v0[i]); end
      if (v0[i]) begin
        checks++; if (DATA_OUT !== d0[i]) begin errors++; $display("FAIL b2b_m0_data[%0d]: got %h exp %h", i, DATA_OUT, d0[i]); end
      end
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_realign;
    do_reset();
    MODE = 1'b1;
    drive(1'b1, 8'hBC);
    MODE = 1'b0;
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    checks++; if (VALID_OUT !== 1'b1) begin errors++; $display("FAIL ra_mode_hold_valid: got %b exp 1", VALID_OUT); end
    checks++; if (DATA_OUT !== 32'h00002211) begin errors++; $display("FAIL ra_mode_hold_data: got %h exp 00002211", DATA_OUT); end
    drive(1'b1, 8'hBC);
    checks++; if (ERR_FRAME !== 1'b0) begin errors++; $display("FAIL ra_err: got %b exp 0", ERR_FRAME); end
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL ra_valid: got %b exp 0", VALID_OUT); end
    checks++; if (ALIGNED !== 1'b1) begin errors++; $display("FAIL ra_aligned: got %b exp 1", ALIGNED); end
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL ra_relatch_valid: got %b exp 0", VALID_OUT); end
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    checks++; if (VALID_OUT !== 1'b1) begin errors++; $display("FAIL ra_word_valid: got %b exp 1", VALID_OUT); end
    checks++; if (DATA_OUT !== 32'h04030201) begin errors++; $display("FAIL ra_word_data: got %h exp 04030201", DATA_OUT); end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_com_mid;
    do_reset();
    MODE = 1'b0;
    drive(1'b1, 8'hBC);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    checks++; if (ERR_FRAME !== 1'b0) begin errors++; $display("FAIL cm_err_pre: got %b exp 0", ERR_FRAME); end
    drive(1'b1, 8'hBC);
    checks++; if (ERR_FRAME !== 1'b1) begin errors++; $display("FAIL cm_err: got %b exp 1", ERR_FRAME); end
    checks++; if (ALIGNED !== 1'b1) begin errors++; $display("FAIL cm_aligned: got %b exp 1", ALIGNED); end
    drive(1'b1, 8'h0A);
    checks++; if (ERR_FRAME !== 1'b0) begin errors++; $display("FAIL cm_err_len: got %b exp 0", ERR_FRAME); end
    drive(1'b1, 8'h0B);
    drive(1'b1, 8'h0C);
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL cm_early: got %b exp 0", VALID_OUT); end
    drive(1'b1, 8'h0D);
    checks++; if (VALID_OUT !== 1'b1) begin errors++; $display("FAIL cm_valid: got %b exp 1", VALID_OUT); end
    checks++; if (DATA_OUT !== 32'h0D0C0B0A) begin errors++; $display("FAIL cm_data: got %h exp 0D0C0B0A", DATA_OUT); end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_gap;
    do_reset();
    MODE = 1'b0;
    // Gap of exactly GAP_MAX cycles is tolerated; COM on an idle cycle is ignored.
    drive(1'b1, 8'hBC);
    drive(1'b1, 8'h01);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'hBC);
    checks++; if (ERR_FRAME !== 1'b0) begin errors++; $display("FAIL gp_tol_err: got %b exp 0", ERR_FRAME); end
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    checks++; if (DATA_OUT !== 32'h04030201 || VALID_OUT !== 1'b1) begin errors++; $display("FAIL gp_tol_word: got %h/%b exp 04030201/1", DATA_OUT, VALID_OUT); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00);
      checks++; if (ERR_FRAME !== 1'b0 || ALIGNED !== 1'b1) begin errors++; $display("FAIL gp_cnt0[%0d]: got err %b al %b exp err 0 al 1", i, ERR_FRAME, ALIGNED); end
    end
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00);
      checks++; if (ERR_FRAME !== 1'b0 || ALIGNED !== 1'b1) begin errors++; $display("FAIL gp_idle[%0d]: got err %b al %b exp err 0 al 1", i, ERR_FRAME, ALIGNED); end
    end
    drive(1'b0, 8'h00);
    checks++; if (ERR_FRAME !== 1'b1) begin errors++; $display("FAIL gp_err: got %b exp 1", ERR_FRAME); end
    checks++; if (ALIGNED !== 1'b0) begin errors++; $display("FAIL gp_aligned: got %b exp 0", ALIGNED); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h05 + 8'(i));
      checks++; if (VALID_OUT !== 1'b0 || ERR_FRAME !== 1'b0) begin errors++; $display("FAIL gp_after[%0d]: got v %b err %b exp 0 0", i, VALID_OUT, ERR_FRAME); end
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_async_reset;
    do_reset();
    MODE = 1'b0;
    drive(1'b1, 8'hBC);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    VALID_IN = 1'b0;
    RESET = 1'b0;
    #1;
    checks++; if (DATA_OUT !== 32'h0) begin errors++; $display("FAIL ar_data: got %h exp 0", DATA_OUT); end
    checks++; if (ALIGNED !== 1'b0) begin errors++; $display("FAIL ar_aligned: got %b exp 0", ALIGNED); end
    checks++; if (VALID_OUT !== 1'b0 || ERR_FRAME !== 1'b0) begin errors++; $display("FAIL ar_strobes: got v %b err %b exp 0 0", VALID_OUT, ERR_FRAME); end
    checks++; if (WORD_CNT !== 16'h0) begin errors++; $display("FAIL ar_wcnt: got %h exp 0", WORD_CNT); end
    @(posedge PCLK);
    #1;
    checks++; if (ERR_FRAME !== 1'b0) begin errors++; $display("FAIL ar_err_hold: got %b exp 0", ERR_FRAME); end
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h03 + 8'(i));
      checks++; if (VALID_OUT !== 1'b0 || ALIGNED !== 1'b0) begin errors++; $display("FAIL ar_after[%0d]: got v %b al %b exp 0 0", i, VALID_OUT, ALIGNED); end
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_word_cnt;
    do_reset();
    MODE = 1'b1;
    drive(1'b1, 8'hBC);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h20 + 8'(i));
    checks++; if (WORD_CNT !== (CNT_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL wc_three: got %0d exp %0d", WORD_CNT, CNT_EN ? 3 : 0); end
    checks++; if (DATA_OUT !== 32'h00002524) begin errors++; $display("FAIL wc_data: got %h exp 00002524", DATA_OUT); end
    drive(1'b0, 8'h00);
    checks++; if (WORD_CNT !== (CNT_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL wc_hold: got %0d exp %0d", WORD_CNT, CNT_EN ? 3 : 0); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_back_to_back();
    test_realign();
    test_com_mid();
    test_gap();
    test_async_reset();
    test_word_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
